// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters.
// Build option ALU_ARB_ILLEGAL_CHK_EN adds the illegal_op output and squashes results of codes > 17.
module alu_share_arbiter #(
  parameter int DATA_W        = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [9:0]          req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [9:0]          req_shamt,
  output logic [4:0]          alu_cnt,
  output logic [DATA_W-1:0]   alu_in1,
  output logic [DATA_W-1:0]   alu_in2,
  output logic [4:0]          alu_shamt,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_result,
  output logic                rsp_zero,
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  output logic                illegal_op,
`endif
  output logic                busy
);

  // state | meaning
  // IDLE  | waiting for a request; req_ready may assert
  // EXEC  | ALU inputs held; cnt_q counts down the op latency
  // DONE  | response captured; rsp_valid pulses for this one cycle

  localparam int              CNT_W   = $clog2(MULDIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [4:0]      OP_IMUL = 5'd15;
  localparam logic [4:0]      OP_DIVI = 5'd16;
  localparam logic [4:0]      OP_MAX  = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic                last_grant_q;
  logic                cur_id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [4:0]          alu_cnt_q;
  logic [DATA_W-1:0]   alu_in1_q;
  logic [DATA_W-1:0]   alu_in2_q;
  logic [4:0]          alu_shamt_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_zero_q;
  logic                busy_q;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic                op_ill_q;
  logic                illegal_op_q;
`endif

  logic                grant_vld;
  logic                grant_id;
  logic [4:0]          g_op;
  logic [DATA_W-1:0]   g_a;
  logic [DATA_W-1:0]   g_b;
  logic [4:0]          g_shamt;
  logic                g_muldiv;

  // Tie goes to whoever did not win last; last_grant resets to 1 so requester 0 wins first.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == S_IDLE) begin
      case (req_valid)
        2'b01: begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end
        2'b10: begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
        2'b11: begin
          grant_vld = 1'b1;
          grant_id  = ~last_grant_q;
        end
        default: begin
          grant_vld = 1'b0;
          grant_id  = 1'b0;
        end
      endcase
    end
  end

  assign req_ready = {grant_vld & grant_id, grant_vld & ~grant_id};

  assign g_op     = grant_id ? req_op[9:5]                 : req_op[4:0];
  assign g_a      = grant_id ? req_a[2*DATA_W-1:DATA_W]    : req_a[DATA_W-1:0];
  assign g_b      = grant_id ? req_b[2*DATA_W-1:DATA_W]    : req_b[DATA_W-1:0];
  assign g_shamt  = grant_id ? req_shamt[9:5]              : req_shamt[4:0];
  assign g_muldiv = (g_op == OP_IMUL) || (g_op == OP_DIVI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      cnt_q        <= '0;
      alu_cnt_q    <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_shamt_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      op_ill_q     <= 1'b0;
      illegal_op_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            alu_cnt_q    <= g_op;
            alu_in1_q    <= g_a;
            alu_in2_q    <= g_b;
            alu_shamt_q  <= g_shamt;
            last_grant_q <= grant_id;
            cur_id_q     <= grant_id;
            cnt_q        <= g_muldiv ? MD_LOAD : '0;
            busy_q       <= 1'b1;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            op_ill_q     <= (g_op > OP_MAX);
`endif
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            rsp_result_q <= op_ill_q ? '0 : alu_result;
            rsp_zero_q   <= ~op_ill_q & alu_zero;
            illegal_op_q <= op_ill_q;
`else
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
`endif
            rsp_id_q     <= cur_id_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          rsp_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
          illegal_op_q <= 1'b0;
`endif
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_cnt    = alu_cnt_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_shamt  = alu_shamt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = busy_q;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  assign illegal_op = illegal_op_q;
`endif

endmodule
